vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 style VGA raster timing from a 50 MHz clock.
//   A divide-by-two phase register gives the 25 MHz pixel clock. The pixel
//   counters advance on the Clk edge where phase==1. Sync and blank outputs
//   are registered from the next counter values so they stay aligned with
//   DrawX/DrawY.
// Ports:
//   Clk, Reset_n        - system clock, async active-low reset
//   status_in[4:0]      - one-hot game status {selecting,waiting,playing,win,lose}
//   DrawX, DrawY        - current pixel column / row
//   VGA_CLK             - 25 MHz pixel clock (phase register)
//   VGA_HS, VGA_VS      - active-low syncs
//   VGA_BLANK_N         - high in the visible region
//   VGA_SYNC_N          - tied low
//   frame_start         - one-Clk pulse when the raster wraps to (0,0)
//   frame_count         - frames completed, modulo 2^16
//   status_out          - status_in captured at frame wrap, only when one-hot
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [4:0]  status_in,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic [4:0]  status_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [4:0] ST_RESET = 5'b10000;

    logic       phase;
    logic [9:0] hc, vc;
    logic [9:0] hc_nxt, vc_nxt;
    logic       h_wrap, frame_wrap;
    logic       status_ok;

    // Next-state counters; the sync/blank registers decode these so every
    // output changes on the same edge as the counters.
    always_comb begin
        h_wrap     = phase && (hc == H_LAST);
        frame_wrap = h_wrap && (vc == V_LAST);
        hc_nxt     = hc;
        vc_nxt     = vc;
        if (phase)
            hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
        if (h_wrap)
            vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign status_ok = (status_in != 5'd0) && ((status_in & (status_in - 5'd1)) == 5'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase       <= 1'b0;
            hc          <= 10'd0;
            vc          <= 10'd0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
            status_out  <= ST_RESET;
        end else begin
            phase       <= ~phase;
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            VGA_HS      <= !((hc_nxt >= HS_BEG) && (hc_nxt <= HS_END));
            VGA_VS      <= !((vc_nxt >= VS_BEG) && (vc_nxt <= VS_END));
            VGA_BLANK_N <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
            frame_start <= frame_wrap;
            // Status is only sampled at the frame boundary so the colour path
            // never sees a change mid-frame; malformed codes are ignored.
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
                if (status_ok)
                    status_out <= status_in;
            end
        end
    end

    assign DrawX      = hc;
    assign DrawY      = vc;
    assign VGA_CLK    = phase;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Reduced raster so many frames fit in a short run.
    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 30
    localparam int VT = VV + VF + VS + VB;   // 17
    localparam int FR = HT * VT;             // pixels per frame

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [4:0]  status_in = 5'b10000;
    logic [9:0]  DrawX, DrawY;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
    logic [15:0] frame_count;
    logic [4:0]  status_out;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .status_in(status_in),
        .DrawX(DrawX), .DrawY(DrawY), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .frame_start(frame_start),
        .frame_count(frame_count), .status_out(status_out)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0]  x, y;
        logic        clk, hs, vs, bn, sn, fs;
        logic [15:0] fc;
        logic [4:0]  st;
    } obs_t;

    obs_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   m_frames = 0;   // model's completed-frame count
    int   fc_off = 0;     // offset applied when frame_count is forced

    function automatic obs_t rst_exp();
        obs_t e;
        e = '{x: 10'd0, y: 10'd0, clk: 1'b0, hs: 1'b1, vs: 1'b1, bn: 1'b1,
              sn: 1'b0, fs: 1'b0, fc: 16'd0, st: 5'b10000};
        return e;
    endfunction

    function automatic obs_t act();
        obs_t a;
        a = '{x: DrawX, y: DrawY, clk: VGA_CLK, hs: VGA_HS, vs: VGA_VS, bn: VGA_BLANK_N,
              sn: VGA_SYNC_N, fs: frame_start, fc: frame_count, st: status_out};
        return a;
    endfunction

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = act();
        n_cmp++;
        if (a !== e) begin
            n_mis++;
            $display("FAIL %s t=%0t act x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b sn=%b fs=%b fc=%0d st=%b | exp x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b sn=%b fs=%b fc=%0d st=%b",
                     name, $time, a.x, a.y, a.clk, a.hs, a.vs, a.bn, a.sn, a.fs, a.fc, a.st,
                     e.x, e.y, e.clk, e.hs, e.vs, e.bn, e.sn, e.fs, e.fc, e.st);
        end
    endtask

    // Reference model: position derived from the number of Clk edges since
    // reset release. Pixel index p = edges/2; raster position is p mod FR.
    initial begin
        int k, p, pos, hc, vc;
        logic [4:0] st_m;
        obs_t e;
        k = 0;
        st_m = 5'b10000;
        forever begin
            @(posedge Clk);
            if (!Reset_n) begin
                k = 0; fc_off = 0; m_frames = 0; st_m = 5'b10000;
                e = rst_exp();
            end else begin
                k++;
                p   = k / 2;
                pos = p % FR;
                hc  = pos % HT;
                vc  = pos / HT;
                m_frames = p / FR;
                e.x  = 10'(hc);
                e.y  = 10'(vc);
                e.clk = 1'(k % 2);
                e.hs = !(hc >= HV + HF && hc < HV + HF + HS);
                e.vs = !(vc >= VV + VF && vc < VV + VF + VS);
                e.bn = (hc < HV) && (vc < VV);
                e.sn = 1'b0;
                e.fs = (k % 2 == 0) && (pos == 0);
                if (e.fs && $countones(status_in) == 1)
                    st_m = status_in;
                e.st = st_m;
                e.fc = 16'(m_frames + fc_off);
            end
            q.push_back(e);
        end
    end

    // Monitor: one expected entry per Clk edge, compared mid-cycle.
    initial begin
        obs_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cycle", e);
            end
        end
    end

    task automatic wait_fs(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (frame_start) break;
        end
        if (i == budget) begin
            n_cmp++; n_mis++;
            $display("FAIL wait_frame_start: no pulse within %0d Clk", budget);
        end
    endtask

    task automatic wait_pos(input int x, input int y, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (DrawX == 10'(x) && DrawY == 10'(y)) break;
        end
        if (i == budget) begin
            n_cmp++; n_mis++;
            $display("FAIL wait_pos(%0d,%0d): not reached within %0d Clk", x, y, budget);
        end
    endtask

    initial begin
        // Reset held, then released between edges.
        repeat (4) @(negedge Clk);
        check("reset_state", rst_exp());
        #2 Reset_n = 1'b1;

        // Status change mid-frame must wait for the wrap.
        wait_pos(0, 5, 3 * FR);
        #2 status_in = 5'b00100;
        wait_fs(3 * FR);

        // Multi-hot code at the wrap is ignored.
        wait_pos(3, 9, 3 * FR);
        #2 status_in = 5'b00110;
        wait_fs(3 * FR);

        // Randomized status codes, some valid, some not.
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(1, 2 * FR - 100)) @(negedge Clk);
            #2;
            if ($urandom_range(0, 1) == 1)
                status_in = 5'b00001 << $urandom_range(0, 4);
            else
                status_in = 5'($urandom);
            wait_fs(3 * FR);
        end

        // Frame counter wrap: preload 65535 mid-frame.
        wait_pos(5, 3, 3 * FR);
        #2;
        force dut.frame_count = 16'hFFFF;
        fc_off = 65535 - m_frames;
        #1 release dut.frame_count;
        wait_fs(3 * FR);
        repeat (10) @(negedge Clk);

        // Asynchronous reset mid-frame.
        wait_pos(10, 6, 3 * FR);
        #2 Reset_n = 1'b0;
        #1 check("async_reset_immediate", rst_exp());
        repeat (6) @(negedge Clk);
        #2 Reset_n = 1'b1;

        // Run on past another wrap after the reset.
        wait_fs(3 * FR);
        repeat (FR) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_mis++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "timeout");
    end

endmodule
